// File: rtl/flux_frame_ctrl_if.sv
// Magnitude stream from the FFT into the frame controller.
// The master drives valid/last/mag and the slave answers with ready.
interface flux_frame_ctrl_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_last;
    logic [W-1:0] in_mag;
    logic         in_ready;

    modport master (
        output in_valid,
        output in_last,
        output in_mag,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_last,
        input  in_mag,
        output in_ready
    );
endinterface

// File: rtl/flux_frame_ctrl.sv
// Frame aligner and beat post-processor for the spectral flux block.
// It discards or pads FFT bins so that the flux block always sees whole
// N-bin frames. It also turns raw flux beats into single-cycle events,
// with a refractory hold-off counted in flux frames.
module flux_frame_ctrl #(
    parameter int N              = 8,
    parameter int W              = 16,
    parameter int HOLDOFF_FRAMES = 4,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear_err,
    flux_frame_ctrl_if.slave up,
    output logic             mag_valid,
    output logic [W-1:0]     mag_sq,
    input  logic             flux_frame_done,
    input  logic             flux_beat,
    output logic             beat_pulse,
    output logic [CNT_W-1:0] beat_count,
    output logic [CNT_W-1:0] frame_count,
    output logic             sync_err,
    output logic             busy
);
    localparam int BIN_W = $clog2(N);
    localparam int PAD_W = $clog2(N + 1);
    localparam int HO_W  = (HOLDOFF_FRAMES > 0) ? $clog2(HOLDOFF_FRAMES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        STREAM = 2'd2,
        PAD    = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [BIN_W-1:0]   bin_cnt_r, bin_cnt_s;
    logic [PAD_W-1:0]   pad_left_r, pad_left_s;
    logic               pad_to_stream_r, pad_to_stream_s;
    logic [HO_W-1:0]    holdoff_cnt_r, holdoff_cnt_s;
    logic               mag_valid_r, mag_valid_s;
    logic [W-1:0]       mag_sq_r, mag_sq_s;
    logic               beat_pulse_r;
    logic [CNT_W-1:0]   beat_count_r, frame_count_r;
    logic               sync_err_r;
    logic               busy_r;
    logic               in_ready_s, accept_s, err_set_s, beat_acc_s;

    // Ready depends only on the current state; samples are taken in SYNC and STREAM.
    always_comb begin
        in_ready_s = (state_r == SYNC) || (state_r == STREAM);
        accept_s   = up.in_valid && in_ready_s;
    end

    assign up.in_ready = in_ready_s;

    // Framing FSM: next state, bin/pad counters and the sample to emit.
    always_comb begin
        state_s         = state_r;
        bin_cnt_s       = bin_cnt_r;
        pad_left_s      = pad_left_r;
        pad_to_stream_s = pad_to_stream_r;
        mag_valid_s     = 1'b0;
        mag_sq_s        = mag_sq_r;
        err_set_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (enable) state_s = SYNC;
                else        state_s = IDLE;
            end
            SYNC: begin
                // A frame boundary takes priority over a simultaneous disable.
                if (accept_s && up.in_last) begin
                    state_s   = STREAM;
                    bin_cnt_s = BIN_W'(0);
                end else if (!enable) begin
                    state_s = IDLE;
                end else begin
                    state_s = SYNC;
                end
            end
            STREAM: begin
                if (accept_s) begin
                    mag_valid_s = 1'b1;
                    mag_sq_s    = up.in_mag;
                    if (bin_cnt_r == BIN_W'(N - 1)) begin
                        bin_cnt_s = BIN_W'(0);
                        if (!up.in_last) begin
                            err_set_s = 1'b1;
                            state_s   = SYNC;
                        end else begin
                            state_s = STREAM;
                        end
                    end else if (up.in_last) begin
                        // Early last: fill the rest of the frame with zeros.
                        err_set_s       = 1'b1;
                        state_s         = PAD;
                        pad_left_s      = PAD_W'(N - 1) - PAD_W'(bin_cnt_r);
                        pad_to_stream_s = 1'b1;
                    end else begin
                        bin_cnt_s = bin_cnt_r + BIN_W'(1);
                    end
                end else if (!enable) begin
                    if (bin_cnt_r == BIN_W'(0)) begin
                        state_s = IDLE;
                    end else begin
                        state_s         = PAD;
                        pad_left_s      = PAD_W'(N) - PAD_W'(bin_cnt_r);
                        pad_to_stream_s = 1'b0;
                    end
                end else begin
                    state_s = STREAM;
                end
            end
            PAD: begin
                mag_valid_s = 1'b1;
                mag_sq_s    = {W{1'b0}};
                pad_left_s  = pad_left_r - PAD_W'(1);
                if (pad_left_r == PAD_W'(1)) begin
                    bin_cnt_s = BIN_W'(0);
                    if (pad_to_stream_r) state_s = STREAM;
                    else                 state_s = IDLE;
                end else begin
                    state_s = PAD;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Hold-off: an accepted beat reloads the counter, and each flux frame drains it.
    always_comb begin
        beat_acc_s = flux_beat && (holdoff_cnt_r == HO_W'(0));
        if (beat_acc_s) begin
            holdoff_cnt_s = HO_W'(HOLDOFF_FRAMES);
        end else if (flux_frame_done && (holdoff_cnt_r != HO_W'(0))) begin
            holdoff_cnt_s = holdoff_cnt_r - HO_W'(1);
        end else begin
            holdoff_cnt_s = holdoff_cnt_r;
        end
    end

    // State and output registers; the synchronous reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= IDLE;
            bin_cnt_r       <= BIN_W'(0);
            pad_left_r      <= PAD_W'(0);
            pad_to_stream_r <= 1'b0;
            holdoff_cnt_r   <= HO_W'(0);
            mag_valid_r     <= 1'b0;
            mag_sq_r        <= {W{1'b0}};
            beat_pulse_r    <= 1'b0;
            beat_count_r    <= {CNT_W{1'b0}};
            frame_count_r   <= {CNT_W{1'b0}};
            sync_err_r      <= 1'b0;
            busy_r          <= 1'b0;
        end else begin
            state_r         <= state_s;
            bin_cnt_r       <= bin_cnt_s;
            pad_left_r      <= pad_left_s;
            pad_to_stream_r <= pad_to_stream_s;
            holdoff_cnt_r   <= holdoff_cnt_s;
            mag_valid_r     <= mag_valid_s;
            mag_sq_r        <= mag_sq_s;
            beat_pulse_r    <= beat_acc_s;
            busy_r          <= (state_s != IDLE);
            if (beat_acc_s && (beat_count_r != {CNT_W{1'b1}})) begin
                beat_count_r <= beat_count_r + CNT_W'(1);
            end else begin
                beat_count_r <= beat_count_r;
            end
            if (flux_frame_done) begin
                frame_count_r <= frame_count_r + CNT_W'(1);
            end else begin
                frame_count_r <= frame_count_r;
            end
            // A framing error in the same cycle wins over clear_err.
            if (err_set_s) begin
                sync_err_r <= 1'b1;
            end else if (clear_err) begin
                sync_err_r <= 1'b0;
            end else begin
                sync_err_r <= sync_err_r;
            end
        end
    end

    assign mag_valid   = mag_valid_r;
    assign mag_sq      = mag_sq_r;
    assign beat_pulse  = beat_pulse_r;
    assign beat_count  = beat_count_r;
    assign frame_count = frame_count_r;
    assign sync_err    = sync_err_r;
    assign busy        = busy_r;
endmodule

// File: tb/tb_flux_frame_ctrl.sv
// Directed bench for flux_frame_ctrl: alignment, padding, resync, hold-off, saturation, reset.
// CNT_W is reduced to 4 so that beat_count saturation and frame_count wrap are reachable.
module tb_flux_frame_ctrl;
    localparam int N     = 8;
    localparam int W     = 16;
    localparam int HO    = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b0;
    logic             clear_err = 1'b0;
    logic             mag_valid;
    logic [W-1:0]     mag_sq;
    logic             flux_frame_done = 1'b0;
    logic             flux_beat = 1'b0;
    logic             beat_pulse;
    logic [CNT_W-1:0] beat_count;
    logic [CNT_W-1:0] frame_count;
    logic             sync_err;
    logic             busy;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_frames = 0;
    int exp_beats  = 0;

    flux_frame_ctrl_if #(.W(W)) up_if ();

    flux_frame_ctrl #(
        .N(N), .W(W), .HOLDOFF_FRAMES(HO), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .clear_err(clear_err),
        .up(up_if.slave),
        .mag_valid(mag_valid),
        .mag_sq(mag_sq),
        .flux_frame_done(flux_frame_done),
        .flux_beat(flux_beat),
        .beat_pulse(beat_pulse),
        .beat_count(beat_count),
        .frame_count(frame_count),
        .sync_err(sync_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else             n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one sample for a single cycle, then check whether it was forwarded.
    task automatic send(input logic [15:0] m, input logic l, input logic fwd);
        up_if.in_valid = 1'b1;
        up_if.in_mag   = m;
        up_if.in_last  = l;
        tick();
        up_if.in_valid = 1'b0;
        up_if.in_last  = 1'b0;
        check("fwd_valid", {31'd0, mag_valid}, {31'd0, fwd});
        if (fwd) check("fwd_data", {16'd0, mag_sq}, {16'd0, m});
    endtask

    initial begin
        up_if.in_valid = 1'b0;
        up_if.in_last  = 1'b0;
        up_if.in_mag   = 16'd0;
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, up_if.in_ready}, 32'd0);
        check("rst_mag_valid", {31'd0, mag_valid}, 32'd0);
        check("rst_counts", {24'd0, beat_count, frame_count}, 32'd0);
        reset  = 1'b0;
        enable = 1'b1;
        tick();
        check("sync_busy", {31'd0, busy}, 32'd1);
        check("sync_ready", {31'd0, up_if.in_ready}, 32'd1);

        // Aligned stream: the first frame is consumed by SYNC.
        for (int i = 0; i < N; i++) send(16'd100 + 16'(i), (i == N - 1), 1'b0);
        for (int f = 0; f < 3; f++) begin
            for (int b = 0; b < N; b++) begin
                check("stream_ready", {31'd0, up_if.in_ready}, 32'd1);
                send(16'h0100 * 16'(f + 1) + 16'(b + 1), (b == N - 1), 1'b1);
            end
        end
        tick();
        check("idle_gap_valid", {31'd0, mag_valid}, 32'd0);
        check("idle_gap_hold", {16'd0, mag_sq}, 32'h0308);
        check("aligned_err", {31'd0, sync_err}, 32'd0);

        // Early last on bin 4: three zero pads, ready low throughout.
        for (int b = 0; b < 5; b++) send(16'h0A00 + 16'(b), (b == 4), 1'b1);
        for (int p = 0; p < 3; p++) begin
            check("pad_ready", {31'd0, up_if.in_ready}, 32'd0);
            tick();
            check("pad_valid", {31'd0, mag_valid}, 32'd1);
            check("pad_zero", {16'd0, mag_sq}, 32'd0);
        end
        check("early_err", {31'd0, sync_err}, 32'd1);
        check("after_pad_ready", {31'd0, up_if.in_ready}, 32'd1);
        // The first sample after the pads is bin 0, so a full frame stays aligned.
        for (int b = 0; b < N; b++) send(16'h0B00 + 16'(b), (b == N - 1), 1'b1);
        check("realigned_ready", {31'd0, up_if.in_ready}, 32'd1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("clear1", {31'd0, sync_err}, 32'd0);

        // Missing last: 8 forwarded, then SYNC discards up to the next last.
        for (int b = 0; b < N; b++) send(16'h0C00 + 16'(b), 1'b0, 1'b1);
        check("missing_err", {31'd0, sync_err}, 32'd1);
        for (int b = 0; b < 5; b++) send(16'h0D00 + 16'(b), (b == 4), 1'b0);
        send(16'h0077, 1'b0, 1'b1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("clear2", {31'd0, sync_err}, 32'd0);
        for (int b = 1; b < N; b++) send(16'h0E00 + 16'(b), (b == N - 1), 1'b1);
        check("missing_realign", {31'd0, up_if.in_ready}, 32'd1);

        // Disable after bin 2: five zero pads, then IDLE.
        for (int b = 0; b < 3; b++) send(16'h0F00 + 16'(b), 1'b0, 1'b1);
        enable = 1'b0;
        tick();
        check("dis_no_emit", {31'd0, mag_valid}, 32'd0);
        for (int p = 0; p < 5; p++) begin
            check("dis_pad_ready", {31'd0, up_if.in_ready}, 32'd0);
            tick();
            check("dis_pad_valid", {31'd0, mag_valid}, 32'd1);
            check("dis_pad_zero", {16'd0, mag_sq}, 32'd0);
        end
        check("dis_busy", {31'd0, busy}, 32'd0);
        check("dis_ready", {31'd0, up_if.in_ready}, 32'd0);
        tick();
        check("dis_quiet", {31'd0, mag_valid}, 32'd0);

        // Hold-off: beat+done on frames 0,1,2,5 gives pulses on 0 and 5.
        for (int f = 0; f < 6; f++) begin
            flux_frame_done = 1'b1;
            flux_beat = (f == 0 || f == 1 || f == 2 || f == 5);
            tick();
            flux_frame_done = 1'b0;
            flux_beat = 1'b0;
            exp_frames++;
            check("ho_pulse", {31'd0, beat_pulse}, {31'd0, (f == 0 || f == 5)});
            tick();
            check("ho_pulse_one", {31'd0, beat_pulse}, 32'd0);
        end
        exp_beats = 2;
        check("ho_beats", {28'd0, beat_count}, 32'd2);
        check("ho_frames", {28'd0, frame_count}, 32'd6);

        // Saturation: drain the hold-off, then land an accepted beat; repeat past all-ones.
        for (int k = 0; k < 15; k++) begin
            flux_frame_done = 1'b1;
            for (int d = 0; d < HO; d++) tick();
            flux_beat = 1'b1;
            tick();
            flux_beat = 1'b0;
            flux_frame_done = 1'b0;
            exp_frames += HO + 1;
            if (exp_beats < 15) exp_beats++;
            check("sat_pulse", {31'd0, beat_pulse}, 32'd1);
            check("sat_beats", {28'd0, beat_count}, exp_beats[31:0]);
            check("wrap_frames", {28'd0, frame_count}, {28'd0, exp_frames[3:0]});
        end
        check("sat_final", {28'd0, beat_count}, 32'd15);

        // Reset mid-STREAM clears everything on the next edge.
        enable = 1'b1;
        tick();
        send(16'h1234, 1'b1, 1'b0);
        send(16'h5678, 1'b0, 1'b1);
        send(16'h9ABC, 1'b0, 1'b1);
        reset = 1'b1;
        up_if.in_valid = 1'b1;
        tick();
        up_if.in_valid = 1'b0;
        check("mrst_mag", {15'd0, mag_valid, mag_sq}, 32'd0);
        check("mrst_counts", {24'd0, beat_count, frame_count}, 32'd0);
        check("mrst_flags", {29'd0, beat_pulse, sync_err, busy}, 32'd0);
        check("mrst_ready", {31'd0, up_if.in_ready}, 32'd0);
        reset  = 1'b0;
        enable = 1'b0;
        tick();
        check("post_rst_idle", {30'd0, busy, mag_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
